// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the 8-bit FIFO and its clients
//
// Contents:
//   FIFO_DATA_W          byte width of the FIFO data path, shared with the FIFO itself
//   fifo_reader_state_t  read-client FSM states
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    BACKOFF,
    OUT
  } fifo_reader_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - byte lane register array and fill index for fifo_reader
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load_i     write byte_i into lane idx and advance idx
//   clear_i    drop all lanes and return idx to 0 (word handed downstream)
//   byte_i     incoming byte
//   data_o     packed word, lane 0 in bits [7:0]
//   count_o    valid byte count (idx with FIFO_READER_FLUSH_EN, else BYTES)
//   last_o     the next load completes the word
//
// Build option: FIFO_READER_FLUSH_EN selects whether count_o tracks idx.
module byte_packer
  import fifo_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int CW    = $clog2(BYTES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic                         clear_i,
  input  logic [FIFO_DATA_W-1:0]       byte_i,
  output logic [BYTES*FIFO_DATA_W-1:0] data_o,
  output logic [CW-1:0]                count_o,
  output logic                         last_o
);

  logic [FIFO_DATA_W-1:0] lane_q [BYTES];
  logic [CW-1:0]          idx_q;

  // Lanes are zeroed on clear so a later partial word never shows stale bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      for (int l = 0; l < BYTES; l++) lane_q[l] <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
      for (int l = 0; l < BYTES; l++) lane_q[l] <= '0;
    end else if (load_i) begin
      idx_q <= idx_q + CW'(1);
      for (int l = 0; l < BYTES; l++) begin
        if (idx_q == CW'(l)) lane_q[l] <= byte_i;
      end
    end
  end

  always_comb begin
    data_o = '0;
    for (int l = 0; l < BYTES; l++) data_o[l*FIFO_DATA_W +: FIFO_DATA_W] = lane_q[l];
  end

  assign last_o = (idx_q == CW'(BYTES - 1));

`ifdef FIFO_READER_FLUSH_EN
  assign count_o = idx_q;
`else
  assign count_o = CW'(BYTES);
`endif

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-side FIFO client packing BYTES bytes per output word
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   enable              permits new read requests (sampled in IDLE, BACKOFF exit, OUT handshake)
//   fifo_read_valid     one-cycle read request to the FIFO
//   fifo_read_data      byte from the FIFO, valid with fifo_read_success
//   fifo_read_success   request served
//   fifo_read_empty     request refused, FIFO empty
//   out_data            packed word, first byte read in bits [7:0]
//   out_valid/out_ready downstream word handshake
//   out_count           number of valid bytes in out_data
//   busy                FSM is not in IDLE
//
// Build option: FIFO_READER_FLUSH_EN enables flushing a partial word after
// FLUSH_TIMEOUT consecutive empty responses.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int BYTES         = 4,
  parameter int RETRY_GAP     = 2,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic                         fifo_read_valid,
  input  logic [FIFO_DATA_W-1:0]       fifo_read_data,
  input  logic                         fifo_read_success,
  input  logic                         fifo_read_empty,
  output logic [BYTES*FIFO_DATA_W-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(BYTES+1)-1:0]   out_count,
  output logic                         busy
);

  localparam int CW = $clog2(BYTES + 1);
  localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  if (BYTES < 2 || BYTES > 8) begin : g_bad_bytes
    $error("fifo_reader: BYTES must be 2..8");
  end
  if (RETRY_GAP < 0) begin : g_bad_gap
    $error("fifo_reader: RETRY_GAP must be >= 0");
  end
  if (FLUSH_TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_reader: FLUSH_TIMEOUT must be >= 1");
  end

  fifo_reader_state_t state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               load, clear, last;
  logic               flush_due;

  // Decision taken whenever the backoff period ends.
  function automatic fifo_reader_state_t after_backoff(input logic due, input logic en);
    if (due)     return OUT;
    else if (en) return REQ;
    else         return IDLE;
  endfunction

`ifdef FIFO_READER_FLUSH_EN
  localparam int FW = $clog2(FLUSH_TIMEOUT + 1);
  logic [FW-1:0] flush_q, flush_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_q <= '0;
    else     flush_q <= flush_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    load      = 1'b0;
    clear     = 1'b0;
    flush_due = 1'b0;
`ifdef FIFO_READER_FLUSH_EN
    flush_d   = flush_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable) state_d = REQ;
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A response carrying both flags is data.
        if (fifo_read_success) begin
          load    = 1'b1;
`ifdef FIFO_READER_FLUSH_EN
          flush_d = '0;
`endif
          state_d = last ? OUT : REQ;
        end else if (fifo_read_empty) begin
          gap_d = '0;
`ifdef FIFO_READER_FLUSH_EN
          // Only empties seen while a partial word is pending count toward a flush.
          if (out_count != '0 && 32'(flush_q) < FLUSH_TIMEOUT) flush_d = flush_q + FW'(1);
          flush_due = (32'(flush_d) >= FLUSH_TIMEOUT);
`endif
          if (RETRY_GAP == 0) state_d = after_backoff(flush_due, enable);
          else                state_d = BACKOFF;
        end
      end
      BACKOFF: begin
`ifdef FIFO_READER_FLUSH_EN
        flush_due = (32'(flush_q) >= FLUSH_TIMEOUT);
`endif
        if (32'(gap_q) + 32'd1 >= RETRY_GAP) state_d = after_backoff(flush_due, enable);
        else                                 gap_d   = gap_q + GW'(1);
      end
      OUT: begin
        if (out_ready) begin
          clear   = 1'b1;
`ifdef FIFO_READER_FLUSH_EN
          flush_d = '0;
`endif
          state_d = enable ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_read_valid = (state_q == REQ);
  assign out_valid       = (state_q == OUT);
  assign busy            = (state_q != IDLE);

  byte_packer #(
    .BYTES (BYTES),
    .CW    (CW)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .clear_i (clear),
    .byte_i  (fifo_read_data),
    .data_o  (out_data),
    .count_o (out_count),
    .last_o  (last)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - self-checking bench for fifo_reader with a queue-based FIFO model
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int BYTES = 4;
  localparam int GAP   = 2;
`ifdef FIFO_READER_FLUSH_EN
  localparam int FT = 4;
`else
  localparam int FT = 16;
`endif
  localparam int CW = $clog2(BYTES + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              fifo_read_valid;
  logic [7:0]        fifo_read_data;
  logic              fifo_read_success;
  logic              fifo_read_empty;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     out_count;
  logic              busy;

  always #5 clk = ~clk;

  fifo_reader #(.BYTES(BYTES), .RETRY_GAP(GAP), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_read_valid(fifo_read_valid), .fifo_read_data(fifo_read_data),
    .fifo_read_success(fifo_read_success), .fifo_read_empty(fifo_read_empty),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: bytes queue, response latency in cycles, optional both-flags response.
  logic [7:0] fifo_q[$];
  logic [7:0] sb_bytes[$];
  int  lat = 1;
  bit  rand_lat = 0;
  bit  both_next = 0;
  bit  sb_on = 0;
  int  pend = 0;
  int  words_seen = 0;

  initial begin : fifo_model
    fifo_read_success = 1'b0;
    fifo_read_empty   = 1'b0;
    fifo_read_data    = 8'h00;
    forever begin
      @(posedge clk); #1;
      fifo_read_success = 1'b0;
      fifo_read_empty   = 1'b0;
      if (rst) pend = 0;
      else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            if (fifo_q.size() > 0) begin
              fifo_read_data    = fifo_q.pop_front();
              fifo_read_success = 1'b1;
              if (both_next) begin fifo_read_empty = 1'b1; both_next = 0; end
              if (sb_on) sb_bytes.push_back(fifo_read_data);
            end else begin
              fifo_read_data  = 8'($urandom);
              fifo_read_empty = 1'b1;
            end
          end
        end
        if (fifo_read_valid) begin
          chk("one_outstanding", 64'(pend), 64'd0);
          pend = rand_lat ? int'($urandom_range(1, 4)) : lat;
        end
      end
    end
  end

  // Stream monitor for the randomized phase: words against the popped byte stream.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb_on && !rst) begin
        if (out_valid) chk("no_req_in_out", 64'(fifo_read_valid), 64'd0);
        if (prev_stall) chk("stall_stable", 64'(out_data), 64'(prev_data));
        if (out_valid && out_ready) begin
          int n;
          logic [31:0] exp;
`ifdef FIFO_READER_FLUSH_EN
          n = int'(out_count);
          chk("rand_count_range", 64'(n >= 1 && n <= BYTES), 64'd1);
`else
          n = BYTES;
          chk("rand_count", 64'(out_count), 64'(BYTES));
`endif
          exp = '0;
          if (sb_bytes.size() < n) chk("rand_sb_underflow", 64'(sb_bytes.size()), 64'(n));
          else for (int i = 0; i < n; i++) exp[8*i +: 8] = sb_bytes.pop_front();
          chk("rand_word", 64'(out_data), 64'(exp));
          words_seen++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end else prev_stall = 1'b0;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    fifo_q.delete(); both_next = 0; lat = 1; rand_lat = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic push4(input logic [31:0] b_msb_first);
    logic [31:0] t;
    t = b_msb_first;
    for (int i = 3; i >= 0; i--) fifo_q.push_back(t[8*i +: 8]);
  endtask

  task automatic wait_valid(input string name, input int budget, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < budget) begin tick(); cyc++; end
    chk(name, 64'(out_valid), 64'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] bytes_in;  // first byte read in the top byte
    int          lat;
    logic [31:0] exp_word;
    int          exp_cyc;
  } vec_t;

  initial begin : main
    vec_t vecs[3];
    int   cyc, pulses, last_pulse, reqs;
    bit   any;
    logic [31:0] d0;

    vecs[0] = '{32'h11223344, 1, 32'h44332211, 8};
    vecs[1] = '{32'hAA00FF55, 2, 32'h55FF00AA, 12};
    vecs[2] = '{32'h80010203, 3, 32'h03020180, 16};

    do_reset();
    chk("reset_read_valid", 64'(fifo_read_valid), 64'd0);
    chk("reset_out_valid",  64'(out_valid), 64'd0);
    chk("reset_busy",       64'(busy), 64'd0);
    chk("reset_out_data",   64'(out_data), 64'd0);
`ifdef FIFO_READER_FLUSH_EN
    chk("reset_out_count",  64'(out_count), 64'd0);
`endif

    for (int v = 0; v < 3; v++) begin
      do_reset();
      push4(vecs[v].bytes_in);
      lat = vecs[v].lat;
      enable = 1'b1;
      tick();
      chk("vec_busy", 64'(busy), 64'd1);
      wait_valid("vec_valid", 60, cyc);
      chk("vec_latency", 64'(cyc), 64'(vecs[v].exp_cyc));
      chk("vec_data", 64'(out_data), 64'(vecs[v].exp_word));
      chk("vec_count", 64'(out_count), 64'(BYTES));
      enable = 1'b0;
      accept();
      chk("vec_valid_drop", 64'(out_valid), 64'd0);
      chk("vec_idle", 64'(busy), 64'd0);
    end

    // Empty FIFO: requests every GAP+2 cycles, no word.
    do_reset();
    enable = 1'b1;
    pulses = 0; last_pulse = -1; any = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (out_valid) any = 1;
      if (fifo_read_valid) begin
        if (last_pulse >= 0) chk("backoff_period", 64'(c - last_pulse), 64'(GAP + 2));
        last_pulse = c;
        pulses++;
      end
    end
    chk("backoff_no_valid", 64'(any), 64'd0);
    chk("backoff_pulses", 64'(pulses >= 5), 64'd1);
    push4(32'h01020304);
    wait_valid("backoff_word_valid", 60, cyc);
    chk("backoff_word", 64'(out_data), 64'h04030201);
    accept();

    // Downstream stall holds the word and blocks requests.
    do_reset();
    push4(32'hDEADBEEF);
    push4(32'h12345678);
    enable = 1'b1;
    wait_valid("stall_valid", 40, cyc);
    d0 = out_data;
    chk("stall_first", 64'(d0), 64'hEFBEADDE);
    any = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (fifo_read_valid || !out_valid || out_data !== d0) any = 1;
    end
    chk("stall_hold", 64'(any), 64'd0);
    accept();
    chk("stall_next_req", 64'(fifo_read_valid), 64'd1);
    chk("stall_valid_drop", 64'(out_valid), 64'd0);
    wait_valid("stall_second_valid", 40, cyc);
    chk("stall_second", 64'(out_data), 64'h78563412);
    accept();

    // Asynchronous reset in the middle of a word.
    do_reset();
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h66);
    enable = 1'b1;
    repeat (8) tick();
    chk("partial_lanes", 64'(out_data), 64'h6655);
    rst = 1'b1;
    #1;
    chk("async_read_valid", 64'(fifo_read_valid), 64'd0);
    chk("async_out_valid",  64'(out_valid), 64'd0);
    chk("async_busy",       64'(busy), 64'd0);
    chk("async_out_data",   64'(out_data), 64'd0);
    do_reset();
    push4(32'hAABBCCDD);
    enable = 1'b1;
    wait_valid("after_reset_valid", 40, cyc);
    chk("after_reset_word", 64'(out_data), 64'hDDCCBBAA);
    accept();

    // Slow FIFO plus one response carrying both flags.
    do_reset();
    lat = 3;
    both_next = 1;
    push4(32'hC0C1C2C3);
    enable = 1'b1;
    reqs = 0; cyc = 0;
    while (!out_valid && cyc < 80) begin
      tick(); cyc++;
      if (fifo_read_valid) reqs++;
    end
    chk("slow_valid", 64'(out_valid), 64'd1);
    chk("slow_reqs", 64'(reqs), 64'd4);
    chk("slow_word", 64'(out_data), 64'hC3C2C1C0);
    enable = 1'b0;
    accept();

`ifdef FIFO_READER_FLUSH_EN
    do_reset();
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    enable = 1'b1;
    wait_valid("flush_valid", 120, cyc);
    chk("flush_word", 64'(out_data), 64'h00000201);
    chk("flush_count", 64'(out_count), 64'd2);
    enable = 1'b0;
    accept();
`endif

    // Randomized traffic against the byte-stream scoreboard.
    do_reset();
    sb_bytes.delete();
    words_seen = 0;
    rand_lat = 1;
    sb_on = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = 1'($urandom_range(0, 1));
    end
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (200) tick();
    sb_on = 0;
    chk("rand_words_seen", 64'(words_seen > 50), 64'd1);
    chk("rand_leftover", 64'(sb_bytes.size() < BYTES), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
